// File: rtl/fb_write_pkg.sv
// Shared constants and state encoding for the framebuffer write sequencer.
// Pixel select helper: pixel 0 lives in the MSB pair of a stream byte.
package fb_write_pkg;

  localparam int ADDR_W       = 11;
  localparam int PIX_W        = 2;
  localparam int BYTE_W       = 8;
  localparam int PIX_PER_BYTE = BYTE_W / PIX_W;
  localparam int IDX_W        = $clog2(PIX_PER_BYTE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UNPACK = 2'd1,
    S_CLEAR  = 2'd2
  } state_e;

  function automatic logic [PIX_W-1:0] pix_sel(
    input logic [BYTE_W-1:0] b,
    input logic [IDX_W-1:0]  i
  );
    return b[BYTE_W-1-PIX_W*int'(i) -: PIX_W];
  endfunction

endpackage

// File: rtl/fb_write_sequencer.sv
// Framebuffer RAM write-port arbiter: byte-stream unpacker plus clear sweep.
// All RAM-side outputs are registered; clear requests defer behind a byte.
module fb_write_sequencer
  import fb_write_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BYTE_W-1:0] wr_byte,
  input  logic              clr_req,
  input  logic [PIX_W-1:0]  clr_value,
  output logic              busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [PIX_W-1:0]  ram_data,
  output logic              ram_we,
  output logic              ram_clken
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIX_PER_BYTE - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, nidx;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic [PIX_W-1:0]   val_q, val_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [BYTE_W-1:0]  byte_q, byte_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [PIX_W-1:0]   data_q, data_d;
  logic               we_q, we_d;
  logic               done_q, done_d;
  logic               go_clr, accept;
  logic [PIX_W-1:0]   go_val;

  assign go_clr = clr_req | pend_q;
  assign go_val = pend_q ? val_q : clr_value;
  assign nidx   = idx_q + 1'b1;

  assign wr_ready = !reset && !clr_req && !pend_q &&
                    ((state_q == S_IDLE) ||
                     (state_q == S_UNPACK && idx_q == IDX_LAST));
  assign accept   = wr_valid && wr_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    val_d   = val_q;
    base_d  = base_q;
    byte_d  = byte_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      S_UNPACK: begin
        if (idx_q != IDX_LAST) begin
          idx_d  = nidx;
          addr_d = base_q + {{(ADDR_W-IDX_W){1'b0}}, nidx};
          data_d = pix_sel(byte_q, nidx);
          we_d   = 1'b1;
          if (clr_req && !pend_q) begin
            pend_d = 1'b1;
            val_d  = clr_value;
          end
        end else if (go_clr) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          pend_d  = 1'b0;
          val_d   = go_val;
          addr_d  = '0;
          data_d  = go_val;
          we_d    = 1'b1;
        end else if (accept) begin
          idx_d  = '0;
          base_d = wr_addr;
          byte_d = wr_byte;
          addr_d = wr_addr;
          data_d = pix_sel(wr_byte, '0);
          we_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (cnt_q == '1) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          addr_d = cnt_q + 1'b1;
          data_d = val_q;
          we_d   = 1'b1;
        end
      end
      default: begin
        if (go_clr) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          pend_d  = 1'b0;
          val_d   = go_val;
          addr_d  = '0;
          data_d  = go_val;
          we_d    = 1'b1;
        end else if (accept) begin
          state_d = S_UNPACK;
          idx_d   = '0;
          base_d  = wr_addr;
          byte_d  = wr_byte;
          addr_d  = wr_addr;
          data_d  = pix_sel(wr_byte, '0);
          we_d    = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      val_q   <= '0;
      base_q  <= '0;
      byte_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      val_q   <= val_d;
      base_q  <= base_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end

  assign busy      = !reset && ((state_q != S_IDLE) || pend_q);
  assign clr_done  = done_q;
  assign ram_addr  = addr_q;
  assign ram_data  = data_q;
  assign ram_we    = we_q;
  assign ram_clken = we_q;

endmodule

// File: tb/tb_fb_write_sequencer.sv
// Scenario bench for fb_write_sequencer: expected RAM writes are queued
// as stimulus is driven and popped by a write monitor.
module tb_fb_write_sequencer;
  import fb_write_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [BYTE_W-1:0] wr_byte = '0;
  logic              clr_req = 1'b0;
  logic [PIX_W-1:0]  clr_value = '0;
  logic              busy, clr_done;
  logic [ADDR_W-1:0] ram_addr;
  logic [PIX_W-1:0]  ram_data;
  logic              ram_we, ram_clken;

  fb_write_sequencer dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_byte(wr_byte),
    .clr_req(clr_req), .clr_value(clr_value),
    .busy(busy), .clr_done(clr_done),
    .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_we(ram_we), .ram_clken(ram_clken)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total = 0;
  logic [ADDR_W+PIX_W-1:0] exp_q[$];
  logic [ADDR_W+PIX_W-1:0] mon_e;
  logic [PIX_W-1:0] mem [0:(2**ADDR_W)-1];
  int we_cnt = 0, run = 0, max_run = 0, done_cnt = 0;

  always @(negedge clk) begin
    if (clr_done) done_cnt++;
    if (ram_we) begin
      we_cnt++;
      run++;
      if (run > max_run) max_run = run;
      mem[ram_addr] = ram_data;
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write addr=%h data=%0d", ram_addr, ram_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({ram_addr, ram_data} !== mon_e || ram_clken !== 1'b1)
          $display("FAIL ram_write got addr=%h data=%0d clken=%b exp addr=%h data=%0d",
                   ram_addr, ram_data, ram_clken,
                   mon_e[ADDR_W+PIX_W-1:PIX_W], mon_e[PIX_W-1:0]);
        else pass_cnt++;
      end
    end else begin
      run = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [ADDR_W-1:0] a, input logic [BYTE_W-1:0] b);
    logic [ADDR_W-1:0] ea;
    logic [BYTE_W-1:0] sh;
    for (int k = 0; k < PIX_PER_BYTE; k++) begin
      ea = a + ADDR_W'(k);
      sh = b >> (BYTE_W - PIX_W - PIX_W * k);
      exp_q.push_back({ea, sh[PIX_W-1:0]});
    end
  endtask

  task automatic push_clear(input logic [PIX_W-1:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({ADDR_W'(i), v});
  endtask

  task automatic send_byte(input logic [ADDR_W-1:0] a, input logic [BYTE_W-1:0] b,
                           output int waits);
    wr_addr = a;
    wr_byte = b;
    wr_valid = 1'b1;
    waits = 0;
    while (!wr_ready && waits < 4000) begin
      step();
      waits++;
    end
    if (!wr_ready) begin
      total++;
      $display("FAIL accept_timeout got ready=%b exp ready=1", wr_ready);
      wr_valid = 1'b0;
      return;
    end
    push_byte(a, b);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      step();
      n++;
    end
    total++;
    if (exp_q.size() != 0)
      $display("FAIL %s_drain got pending=%0d exp pending=0", name, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wr_valid = 1'b1;
    repeat (3) step();
    total++; if (ram_we !== 1'b0) $display("FAIL rst_we got %b exp 0", ram_we); else pass_cnt++;
    total++; if (ram_clken !== 1'b0) $display("FAIL rst_clken got %b exp 0", ram_clken); else pass_cnt++;
    total++; if (ram_addr !== '0) $display("FAIL rst_addr got %h exp 0", ram_addr); else pass_cnt++;
    total++; if (ram_data !== '0) $display("FAIL rst_data got %h exp 0", ram_data); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else pass_cnt++;
    total++; if (clr_done !== 1'b0) $display("FAIL rst_done got %b exp 0", clr_done); else pass_cnt++;
    total++; if (wr_ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", wr_ready); else pass_cnt++;
    wr_valid = 1'b0;
    reset = 1'b0;
    step();
    total++; if (wr_ready !== 1'b1) $display("FAIL idle_ready got %b exp 1", wr_ready); else pass_cnt++;
    total++; if (ram_we !== 1'b0) $display("FAIL idle_we got %b exp 0", ram_we); else pass_cnt++;
  endtask

  task automatic test_single();
    int w;
    we_cnt = 0;
    send_byte(11'h010, 8'hE4, w);
    total++; if (w !== 0) $display("FAIL single_wait got %0d exp 0", w); else pass_cnt++;
    repeat (6) step();
    total++; if (we_cnt !== 4) $display("FAIL single_we_cycles got %0d exp 4", we_cnt); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL single_busy got %b exp 0", busy); else pass_cnt++;
    total++; if (ram_addr !== 11'h013) $display("FAIL single_hold_addr got %h exp 013", ram_addr); else pass_cnt++;
    total++; if (exp_q.size() != 0) $display("FAIL single_drain got %0d exp 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_wrap();
    int w;
    send_byte(11'h7FE, 8'h1B, w);
    wait_drain("wrap");
    step();
  endtask

  task automatic test_back_to_back();
    int w0, w1, w2;
    max_run = 0;
    send_byte(11'h040, 8'h5A, w0);
    send_byte(11'h200, 8'hC3, w1);
    send_byte(11'h7F0, 8'h96, w2);
    total++; if (w0 !== 0) $display("FAIL b2b_wait0 got %0d exp 0", w0); else pass_cnt++;
    total++; if (w1 !== 3) $display("FAIL b2b_wait1 got %0d exp 3", w1); else pass_cnt++;
    total++; if (w2 !== 3) $display("FAIL b2b_wait2 got %0d exp 3", w2); else pass_cnt++;
    wait_drain("b2b");
    step();
    total++; if (max_run !== 12) $display("FAIL b2b_we_run got %0d exp 12", max_run); else pass_cnt++;
  endtask

  task automatic test_clear();
    int k, bad;
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
    done_cnt = 0;
    clr_value = 2'd2;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    push_clear(2'd2, 2**ADDR_W);
    total++; if (busy !== 1'b1) $display("FAIL clr_busy got %b exp 1", busy); else pass_cnt++;
    k = 1;
    while (!clr_done && k < 3000) begin
      step();
      k++;
    end
    total++; if (k !== 2049) $display("FAIL clr_done_latency got %0d exp 2049", k); else pass_cnt++;
    step();
    step();
    total++; if (done_cnt !== 1) $display("FAIL clr_done_pulses got %0d exp 1", done_cnt); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL clr_busy_after got %b exp 0", busy); else pass_cnt++;
    total++; if (exp_q.size() != 0) $display("FAIL clr_drain got %0d exp 0", exp_q.size()); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 2**ADDR_W; i++) if (mem[i] !== 2'd2) bad++;
    total++; if (bad !== 0) $display("FAIL clr_readback got %0d bad entries exp 0", bad); else pass_cnt++;
  endtask

  task automatic test_collide_idle();
    int w;
    done_cnt = 0;
    wr_addr = 11'h020;
    wr_byte = 8'h6C;
    wr_valid = 1'b1;
    clr_value = 2'd1;
    clr_req = 1'b1;
    #1;
    total++; if (wr_ready !== 1'b0) $display("FAIL col_idle_ready got %b exp 0", wr_ready); else pass_cnt++;
    step();
    clr_req = 1'b0;
    push_clear(2'd1, 2**ADDR_W);
    send_byte(11'h020, 8'h6C, w);
    total++; if (w !== 2048) $display("FAIL col_idle_wait got %0d exp 2048", w); else pass_cnt++;
    total++; if (done_cnt !== 1) $display("FAIL col_idle_done got %0d exp 1", done_cnt); else pass_cnt++;
    wait_drain("col_idle");
    step();
  endtask

  task automatic test_collide_unpack();
    int w, n;
    max_run = 0;
    done_cnt = 0;
    send_byte(11'h100, 8'hB1, w);
    step();
    clr_value = 2'd3;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL col_unp_busy got %b exp 1", busy); else pass_cnt++;
    step();
    total++; if (wr_ready !== 1'b0) $display("FAIL col_unp_ready got %b exp 0", wr_ready); else pass_cnt++;
    push_clear(2'd3, 2**ADDR_W);
    wait_drain("col_unp");
    n = 0;
    while (done_cnt == 0 && n < 10) begin
      step();
      n++;
    end
    step();
    total++; if (max_run !== 2052) $display("FAIL col_unp_we_run got %0d exp 2052", max_run); else pass_cnt++;
    total++; if (done_cnt !== 1) $display("FAIL col_unp_done got %0d exp 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid_clear();
    int w;
    clr_value = 2'd1;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    push_clear(2'd1, 'h301);
    repeat ('h300) step();
    total++; if (ram_addr !== 11'h300 || ram_we !== 1'b1)
      $display("FAIL rmc_addr got %h we=%b exp 300 we=1", ram_addr, ram_we); else pass_cnt++;
    reset = 1'b1;
    done_cnt = 0;
    step();
    total++; if (ram_we !== 1'b0) $display("FAIL rmc_we got %b exp 0", ram_we); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL rmc_busy got %b exp 0", busy); else pass_cnt++;
    reset = 1'b0;
    repeat (5) step();
    total++; if (done_cnt !== 0) $display("FAIL rmc_done got %0d exp 0", done_cnt); else pass_cnt++;
    total++; if (exp_q.size() != 0) $display("FAIL rmc_writes got %0d left exp 0", exp_q.size()); else pass_cnt++;
    send_byte(11'h123, 8'h27, w);
    total++; if (w !== 0) $display("FAIL rmc_accept_wait got %0d exp 0", w); else pass_cnt++;
    wait_drain("rmc");
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_back_to_back();
    test_clear();
    test_collide_idle();
    test_collide_unpack();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
